// File: rtl/noc_pkg.sv
// Shared flit format and error-bit indices
// for the tile-side NoC endpoint.
package noc_pkg;

  localparam int COORD_W = 4;
  localparam int FLIT_W  = 16;

  typedef struct packed {
    logic [7:0]         payload;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
  } flit_t;

  localparam int ERR_RX_OVF   = 0;
  localparam int ERR_CRED_OVF = 1;
  localparam int ERR_MISROUTE = 2;

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit FIFO with
// separate occupancy counter.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & !empty;
  // A pop frees the slot in the same cycle
  assign do_push = push & (!full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop)
        rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/noc_local_endpoint.sv
// Local-port network interface: credit-gated
// TX injection and FWFT RX buffer with credit return.
module noc_local_endpoint
  import noc_pkg::*;
#(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4,
  parameter int CW         = $clog2(TX_CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [3:0]        tx_dst_x_i,
  input  logic [3:0]        tx_dst_y_i,
  input  logic [7:0]        tx_payload_i,
  output logic [15:0]       net_data_o,
  output logic              net_enable_o,
  input  logic              net_credit_i,
  input  logic [15:0]       net_data_i,
  input  logic              net_enable_i,
  output logic              net_credit_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [7:0]        rx_payload_o,
  output logic [CW-1:0]     credit_cnt_o,
  output logic [2:0]        err_o
);

  localparam logic [CW-1:0] CMAX = CW'(TX_CREDITS);
  localparam int RCW = $clog2(RX_DEPTH + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          send;
  logic          cred_ovf;
  flit_t         tx_flit;
  flit_t         rx_in;
  flit_t         rx_head;
  logic          rx_full;
  logic          rx_empty;
  logic [RCW-1:0] rx_count;
  logic          rx_pop;
  logic          rx_ovf;
  logic          misroute;

  assign tx_ready_o   = (cnt != '0);
  assign credit_cnt_o = cnt;
  assign send         = tx_valid_i & tx_ready_o;

  assign tx_flit.payload = tx_payload_i;
  assign tx_flit.dst_x   = tx_dst_x_i;
  assign tx_flit.dst_y   = tx_dst_y_i;

  always_comb begin
    cnt_nxt  = cnt;
    cred_ovf = 1'b0;
    unique case (1'b1)
      send & !net_credit_i:
        cnt_nxt = cnt - CW'(1);
      !send & net_credit_i:
        if (cnt == CMAX) cred_ovf = 1'b1;
        else             cnt_nxt  = cnt + CW'(1);
      default: ;
    endcase
  end

  assign rx_in    = flit_t'(net_data_i);
  assign rx_valid_o = (rx_count != '0);
  assign rx_pop   = rx_valid_o & rx_ready_i;
  assign rx_ovf   = net_enable_i & rx_full & !rx_pop;
  assign misroute = net_enable_i &
    ((rx_in.dst_x != COORD_W'(XCOORD)) |
     (rx_in.dst_y != COORD_W'(YCOORD)));
  assign rx_payload_o = rx_empty ? 8'h00 : rx_head.payload;

  noc_flit_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (net_enable_i),
    .din   (net_data_i),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= CMAX;
      net_enable_o <= 1'b0;
      net_data_o   <= '0;
      net_credit_o <= 1'b0;
      err_o        <= '0;
    end else begin
      cnt          <= cnt_nxt;
      net_enable_o <= send;
      if (send)
        net_data_o <= tx_flit;
      net_credit_o <= rx_pop;
      if (rx_ovf)   err_o[ERR_RX_OVF]   <= 1'b1;
      if (cred_ovf) err_o[ERR_CRED_OVF] <= 1'b1;
      if (misroute) err_o[ERR_MISROUTE] <= 1'b1;
    end
  end

endmodule

// File: doc/noc_local_endpoint.md
Name: noc_local_endpoint

Overview:
- Tile-side network interface that terminates a router's Local (L) port; it is the far end of the router's credit-based link in both directions.
- TX path: accepts single-flit packets from the core, formats 16-bit flits and injects them into the router L input, gated by a credit counter.
- RX path: buffers flits ejected by the router L output, presents them to the core with valid/ready, and returns one credit per flit the core consumes.

Parameters:
- XCOORD, 0, this tile's X coordinate (4 bits used).
- YCOORD, 0, this tile's Y coordinate (4 bits used).
- TX_CREDITS, 4, depth of the router L input FIFO; initial and maximum credit count.
- RX_DEPTH, 4, local RX buffer depth in flits (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- tx_valid_i  in  1  core has a packet to send
- tx_ready_o  out  1  endpoint can accept a packet this cycle
- tx_dst_x_i  in  4  destination X
- tx_dst_y_i  in  4  destination Y
- tx_payload_i  in  8  payload byte
- net_data_o  out  16  flit to router L input
- net_enable_o  out  1  flit valid strobe to router
- net_credit_i  in  1  credit-return pulse from router (one slot freed)
- net_data_i  in  16  flit from router L output
- net_enable_i  in  1  flit valid strobe from router
- net_credit_o  out  1  credit-return pulse to router
- rx_valid_o  out  1  RX flit available
- rx_ready_i  in  1  core consumes RX flit
- rx_payload_o  out  8  payload of head RX flit
- credit_cnt_o  out  $clog2(TX_CREDITS+1)  current TX credits (debug)
- err_o  out  3  sticky errors: [0] RX overflow, [1] credit overflow, [2] misrouted flit

Behaviour:
- Flit format: [15:8] payload, [7:4] dest X, [3:0] dest Y.
- Reset (rst=0, async): net_enable_o=0, net_data_o=0, net_credit_o=0, RX FIFO empty (rx_valid_o=0, rx_payload_o=0), credits=TX_CREDITS, err_o=0.
- Reset mid-operation: in-flight flits are discarded and credits are reloaded. Router and endpoint share the same reset.

TX path:
- tx_ready_o = (credits != 0). It is a combinational decode of the registered count only; it does not depend on tx_valid_i.
- Handshake: tx_valid_i & tx_ready_o at edge N.
  - Cycle N+1: net_enable_o=1, net_data_o={payload,dst_x,dst_y}.
  - Credits decrement at edge N.
- Otherwise net_enable_o=0 and net_data_o holds its last value.
- Throughput is one flit per cycle while credits > 0.
- net_credit_i increments credits.
- Send and credit in the same cycle: count unchanged.
- Credit arriving at count==TX_CREDITS (with no send): count saturates and err_o[1] is set.

RX path:
- FIFO is first-word-fall-through.
  - rx_valid_o = !empty.
  - rx_payload_o = head[15:8], combinational from storage.
- net_enable_i writes net_data_i.
- Write while full with no simultaneous pop: flit is dropped, err_o[0] is set.
- Write while full with a simultaneous pop: accepted.
- Pop on rx_valid_o & rx_ready_i. net_credit_o pulses for exactly 1 cycle, registered, in the cycle after each pop.
- Back-to-back pops produce back-to-back credit pulses.
- Written flit with [7:4]!=XCOORD or [3:0]!=YCOORD: err_o[2] is set and the flit is still buffered.
- Empty FIFO and rx_ready_i=1: no pop, no credit.
- Pointers wrap modulo RX_DEPTH. Occupancy is a separate counter of width $clog2(RX_DEPTH+1).
- err_o bits are sticky until reset.

Decomposition:
- noc_pkg contains:
  - COORD_W=4, FLIT_W=16.
  - Packed struct flit_t {payload[7:0], dst_x[3:0], dst_y[3:0]}.
  - Error-bit index constants ERR_RX_OVF=0, ERR_CRED_OVF=1, ERR_MISROUTE=2.
- Sub-module noc_flit_fifo (parameter DEPTH, FWFT, push/pop/full/empty/count). It is reused for the RX buffer.
- TX credit logic stays in the top module.

Test Plan:
- Reset, TX_CREDITS=4: hold tx_valid_i=1 for 6 cycles with no net_credit_i.
  - Exactly 4 net_enable_o pulses on consecutive cycles; tx_ready_o=0 afterwards; credit_cnt_o=0.
  - Then one net_credit_i pulse: tx_ready_o=1 next cycle and one further flit is sent.
- Send dst_x=2, dst_y=3, payload=0xA5 -> net_data_o=0xA523 with net_enable_o=1 exactly one cycle after the handshake.
- At credits=2, assert a send and net_credit_i in the same cycle -> credit_cnt_o stays 2.
- Extra net_credit_i at credits=4 -> count stays 4, err_o[1]=1.
- XCOORD=1, YCOORD=1, RX_DEPTH=4: inject 4 flits 0x1011,0x2011,0x3011,0x4011 with rx_ready_i=0 -> rx_valid_o=1, rx_payload_o=0x10, net_credit_o never pulses.
  - A 5th flit with no pop -> dropped, err_o[0]=1.
  - Then rx_ready_i=1 for 4 cycles -> payloads 0x10,0x20,0x30,0x40 in order, and 4 consecutive net_credit_o pulses each lagging its pop by 1 cycle.
- Inject flit 0x7722 at tile (1,1) -> err_o[2]=1, rx_payload_o=0x77.
- Assert rst=0 mid-stream (asynchronous, between edges) -> all outputs clear immediately; credit_cnt_o=4 on release.
